// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter that shares the single write port of sync_fifo between
//   N producer blocks. One winner is picked per cycle with zero latency. The
//   winner gets a same-cycle ack, and its word is presented on fifo_data with
//   fifo_wr_en. No ack is issued while fifo_full is high.
//
//   Optional feature macro: FIFO_ARB_BURST_EN
//     defined   : the last winner stays locked for up to MAX_BURST consecutive
//                 transfers while it keeps requesting.
//     undefined : strict one-word round robin.
//
// Parameters
//   N          number of requesters (2..16)
//   WIDTH      data word width (matches sync_fifo)
//   ID_W       grant index width, must equal clog2(N)
//   MAX_BURST  max consecutive grants to one requester (burst build, >=1)
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous reset, active-high
//   req        in   [N]       req[i]: requester i holds a valid word
//   req_data   in   [N*WIDTH] word i at [i*WIDTH +: WIDTH]
//   fifo_full  in   sync_fifo full flag
//   ack        out  [N]       one-hot-or-zero; word i written this cycle
//   fifo_wr_en out  sync_fifo write enable
//   fifo_data  out  [WIDTH]   sync_fifo data_in (0 when idle)
//   last_id    out  [ID_W]    index of the most recent winner (registered)
//   busy       out  registered: a write happened in the previous cycle
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   req_data,
  input  logic                 fifo_full,
  output logic [N-1:0]         ack,
  output logic                 fifo_wr_en,
  output logic [WIDTH-1:0]     fifo_data,
  output logic [ID_W-1:0]      last_id,
  output logic                 busy
);

  // Elaboration-time sanity checks on the configuration.
  if (N < 2 || N > 16) begin : g_bad_n
    $error("fifo_wr_arbiter: N must be in 2..16");
  end
  if (ID_W != $clog2(N)) begin : g_bad_idw
    $error("fifo_wr_arbiter: ID_W must equal clog2(N)");
  end
  if (MAX_BURST < 1) begin : g_bad_burst
    $error("fifo_wr_arbiter: MAX_BURST must be >= 1");
  end

  // Round-robin pointer holds the previous winner; the search starts one past it.
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_last_id;
  logic            r_busy;

  logic            w_rr_found;
  logic [ID_W-1:0] w_rr_idx;
  logic            w_win_found;
  logic [ID_W-1:0] w_win_idx;
  logic            w_wr;

  // Round-robin search: ptr+1, ptr+2, ... wrapping modulo N (ptr itself last).
  always_comb begin : rr_search
    int unsigned v_idx;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    v_idx      = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      v_idx = 32'(r_ptr) + k;
      if (v_idx >= N) begin
        v_idx = v_idx - N;
      end
      if (!w_rr_found && req[v_idx[ID_W-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = v_idx[ID_W-1:0];
      end
    end
  end

`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ST_OPEN,
    ST_LOCKED
  } lock_state_t;

  lock_state_t      r_state;
  lock_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0] w_burst_cnt_nxt;
  logic             w_hold;
  logic [CNT_W-1:0] w_cnt_inc;

  // While locked, the owner is r_ptr (the previous winner). A locked state
  // always has burst_cnt < MAX_BURST, because reaching the limit reopens the
  // round robin.
  assign w_hold      = (r_state == ST_LOCKED) && req[r_ptr];
  assign w_win_found = w_hold || w_rr_found;
  assign w_win_idx   = w_hold ? r_ptr : w_rr_idx;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_OPEN;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  // Next-state logic. A stall (fifo_full) freezes the lock and the count.
  // A transfer continues the burst or starts a new one. An unstalled cycle
  // without a transfer means the owner dropped req, so the lock is released.
  always_comb begin
    w_state_nxt     = r_state;
    w_burst_cnt_nxt = r_burst_cnt;
    w_cnt_inc       = CNT_W'(1);
    if (!fifo_full) begin
      if (w_wr) begin
        if (w_hold) begin
          w_cnt_inc = r_burst_cnt + CNT_W'(1);
        end
        if (w_cnt_inc >= CNT_W'(MAX_BURST)) begin
          w_state_nxt     = ST_OPEN;
          w_burst_cnt_nxt = '0;
        end else begin
          w_state_nxt     = ST_LOCKED;
          w_burst_cnt_nxt = w_cnt_inc;
        end
      end else begin
        w_state_nxt     = ST_OPEN;
        w_burst_cnt_nxt = '0;
      end
    end
  end
`else
  assign w_win_found = w_rr_found;
  assign w_win_idx   = w_rr_idx;
`endif

  // A write happens only when a winner exists, the FIFO has room and the
  // block is not in reset.
  assign w_wr = !rst && !fifo_full && w_win_found;

  // Output logic. The per-index compare keeps ack one-hot by construction.
  always_comb begin
    ack        = '0;
    fifo_data  = '0;
    fifo_wr_en = w_wr;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_wr && (w_win_idx == ID_W'(i))) begin
        ack[i]    = 1'b1;
        fifo_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer and status registers. ptr resets to N-1 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= ID_W'(N - 1);
      r_last_id <= '0;
      r_busy    <= 1'b0;
    end else if (w_wr) begin
      r_ptr     <= w_win_idx;
      r_last_id <= w_win_idx;
      r_busy    <= 1'b1;
    end else begin
      r_busy    <= 1'b0;
    end
  end

  assign last_id = r_last_id;
  assign busy    = r_busy;

endmodule
